// File: rtl/key_shift_loader.sv
// ---------------------------------------------------------------------------
// key_shift_loader
//
// Serial key loader for a locked controller FSM. A key arrives MSB first
// over a valid/ready handshake, is shifted into a holding register and, once
// complete, is committed to the parallel keyinput bus. The downstream FSM is
// held in reset (fsm_rst=1) until the committed key has been stable on the
// bus for one full cycle. A load_start in any state restarts the load.
//
// Optional feature (compile-time macro): KEY_LOADER_PARITY_EN
//   defined   : every load carries one extra even-parity beat after the key
//               bits; a parity mismatch enters ERROR and sets err.
//   undefined : loads are exactly KEY_W beats and err is tied low.
//
// Parameters
//   KEY_W      key width presented to the downstream FSM, 1..32
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   load_start single-cycle request to begin a new load
//   sdata      serial key bit, MSB first
//   svalid     sdata valid; held until accepted
//   sready     beat accepted this cycle when svalid && sready
//   keyinput   committed parallel key (registered)
//   key_valid  keyinput holds a committed key
//   fsm_rst    active-high reset for the downstream FSM (registered)
//   busy       load in progress (SHIFT, PARITY or COMMIT)
//   err        last load failed; sticky until the next load_start
// ---------------------------------------------------------------------------
module key_shift_loader #(
  parameter int KEY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             sdata,
  input  logic             svalid,
  output logic             sready,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             fsm_rst,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PARITY,
    COMMIT,
    ARMED,
    ERROR
  } state_t;

  state_t           state;
  logic [KEY_W-1:0] shreg;
  logic [KEY_W-1:0] shreg_next;
  logic [CNT_W-1:0] cnt;
  logic             last_beat;

  // Shift written as shift-or so it also holds for KEY_W == 1.
  assign shreg_next = (shreg << 1) | KEY_W'(sdata);
  assign last_beat  = (cnt == CNT_W'(KEY_W - 1));

  // A restart in the same cycle blocks the beat so no stale bit leaks into
  // the fresh load.
  assign sready = ((state == SHIFT) || (state == PARITY)) && !load_start;
  assign busy   = (state == SHIFT) || (state == PARITY) || (state == COMMIT);

`ifdef KEY_LOADER_PARITY_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the shift register is a plain register, not a memory, so it is
  // reset along with the rest of the state and costs nothing extra.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      keyinput  <= '0;
      key_valid <= 1'b0;
      fsm_rst   <= 1'b1;
`ifdef KEY_LOADER_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else if (load_start) begin
      // Fresh entry from any state; keyinput keeps its previous value until
      // the next commit (or an error zeroes it).
      state     <= SHIFT;
      shreg     <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      fsm_rst   <= 1'b1;
`ifdef KEY_LOADER_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: ;

        SHIFT: begin
          // sready is high here because load_start is low on this branch.
          if (svalid) begin
            shreg <= shreg_next;
            cnt   <= cnt + 1'b1;
            if (last_beat) begin
`ifdef KEY_LOADER_PARITY_EN
              state <= PARITY;
`else
              state <= COMMIT;
`endif
            end
          end
        end

`ifdef KEY_LOADER_PARITY_EN
        PARITY: begin
          if (svalid) begin
            // Even parity: the parity bit equals the XOR of all key bits.
            if (sdata == ^shreg) begin
              state <= COMMIT;
            end else begin
              state     <= ERROR;
              err_q     <= 1'b1;
              keyinput  <= '0;
              key_valid <= 1'b0;
              fsm_rst   <= 1'b1;
            end
          end
        end

        ERROR: ;
`endif

        COMMIT: begin
          keyinput  <= shreg;
          key_valid <= 1'b1;
          state     <= ARMED;
        end

        // Releasing reset one edge after the commit keeps the key stable on
        // the bus for a full cycle before the downstream FSM runs.
        ARMED: fsm_rst <= 1'b0;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_shift_loader.sv
// ---------------------------------------------------------------------------
// tb_key_shift_loader
//
// Directed self-checking bench for key_shift_loader with KEY_W = 8. Inputs
// change 1 time unit after the rising edge; outputs are read there too, well
// away from the next active edge. Parity-specific cases are included only
// when KEY_LOADER_PARITY_EN is defined, matching the DUT build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_shift_loader;

  localparam int KEY_W = 8;

  logic             clk;
  logic             rst;
  logic             load_start;
  logic             sdata;
  logic             svalid;
  logic             sready;
  logic [KEY_W-1:0] keyinput;
  logic             key_valid;
  logic             fsm_rst;
  logic             busy;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_beats = 0;

  key_shift_loader #(.KEY_W(KEY_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .sdata     (sdata),
    .svalid    (svalid),
    .sready    (sready),
    .keyinput  (keyinput),
    .key_valid (key_valid),
    .fsm_rst   (fsm_rst),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every transferred beat, independent of the stimulus tasks.
  always @(posedge clk) begin
    if (rst && svalid && sready) n_beats <= n_beats + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    #1;
  endtask

  // Presents one beat and waits (bounded) for it to transfer; svalid is
  // left high so consecutive calls produce back-to-back beats.
  task automatic send_bit(input logic b);
    bit done;
    done   = 1'b0;
    sdata  = b;
    svalid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (sready) done = 1'b1;
      tick();
    end
    if (!done) check("beat_timeout_sready", {31'd0, sready}, 32'd1);
  endtask

  // Sends a full key MSB first, plus the correct parity beat when enabled.
  task automatic send_key(input logic [KEY_W-1:0] k);
    for (int i = KEY_W - 1; i >= 0; i--) send_bit(k[i]);
`ifdef KEY_LOADER_PARITY_EN
    send_bit(^k);
`endif
  endtask

  // Key load with svalid gaps of random length; sdata is garbage while idle.
  task automatic send_key_gapped(input logic [KEY_W-1:0] k);
    logic [KEY_W:0] bits;
`ifdef KEY_LOADER_PARITY_EN
    bits = {k, ^k};
    for (int i = KEY_W; i >= 0; i--) begin
`else
    bits = {1'b0, k};
    for (int i = KEY_W - 1; i >= 0; i--) begin
`endif
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        svalid = 1'b0;
        sdata  = 1'($urandom);
        tick();
      end
      send_bit(bits[i]);
    end
    svalid = 1'b0;
  endtask

  initial begin
    int beats0;
    rst        = 1'b0;
    load_start = 1'b0;
    sdata      = 1'b0;
    svalid     = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Reset followed by idle cycles.
    for (int i = 0; i < 10; i++) tick();
    check("idle_keyinput",  {24'd0, keyinput}, 32'h00);
    check("idle_key_valid", {31'd0, key_valid}, 32'd0);
    check("idle_fsm_rst",   {31'd0, fsm_rst},  32'd1);
    check("idle_sready",    {31'd0, sready},   32'd0);
    check("idle_busy",      {31'd0, busy},     32'd0);
    check("idle_err",       {31'd0, err},      32'd0);

    // svalid while idle is ignored.
    svalid = 1'b1;
    sdata  = 1'b1;
    tick();
    tick();
    svalid = 1'b0;
    check("idle_svalid_busy", {31'd0, busy}, 32'd0);

    // Basic load of 0xA5 (bits 1,0,1,0,0,1,0,1) back to back.
    do_start();
    check("start_sready", {31'd0, sready}, 32'd1);
    check("start_busy",   {31'd0, busy},   32'd1);
    send_key(8'hA5);
    svalid = 1'b0;
    // Last beat just accepted: state is COMMIT, bus not updated yet.
    check("commit_key_valid", {31'd0, key_valid}, 32'd0);
    check("commit_busy",      {31'd0, busy},      32'd1);
    check("commit_sready",    {31'd0, sready},    32'd0);
    tick();
    check("a5_keyinput",  {24'd0, keyinput}, 32'hA5);
    check("a5_key_valid", {31'd0, key_valid}, 32'd1);
    check("a5_fsm_rst_held", {31'd0, fsm_rst}, 32'd1);
    tick();
    check("a5_fsm_rst_rel", {31'd0, fsm_rst}, 32'd0);
    check("a5_busy",        {31'd0, busy},    32'd0);
    check("a5_err",         {31'd0, err},     32'd0);

    // svalid while armed: no effect on the bus.
    svalid = 1'b1;
    sdata  = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    svalid = 1'b0;
    check("armed_hold_keyinput", {24'd0, keyinput}, 32'hA5);
    check("armed_hold_fsm_rst",  {31'd0, fsm_rst},  32'd0);

`ifdef KEY_LOADER_PARITY_EN
    // Bad parity on 0xA5: parity bit 1 instead of 0.
    do_start();
    for (int i = KEY_W - 1; i >= 0; i--) send_bit(((8'hA5 >> i) & 8'h1) != 0);
    send_bit(1'b1);
    svalid = 1'b0;
    check("badpar_err",       {31'd0, err},       32'd1);
    check("badpar_keyinput",  {24'd0, keyinput},  32'h00);
    check("badpar_key_valid", {31'd0, key_valid}, 32'd0);
    check("badpar_fsm_rst",   {31'd0, fsm_rst},   32'd1);
    tick();
    tick();
    check("badpar_err_sticky", {31'd0, err},     32'd1);
    check("badpar_fsm_rst2",   {31'd0, fsm_rst}, 32'd1);
    do_start();
    check("badpar_err_clear",  {31'd0, err},  32'd0);
    send_key(8'hA5);
    svalid = 1'b0;
    tick();
    tick();
    check("rearm_keyinput", {24'd0, keyinput}, 32'hA5);
    check("rearm_fsm_rst",  {31'd0, fsm_rst},  32'd0);
`endif

    // Reload from ARMED: 4 beats, then a restart with svalid high.
    do_start();
    check("reload_key_valid", {31'd0, key_valid}, 32'd0);
    check("reload_fsm_rst",   {31'd0, fsm_rst},   32'd1);
    check("reload_key_kept",  {24'd0, keyinput},  32'hA5);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    load_start = 1'b1;
    svalid     = 1'b1;
    sdata      = 1'b1;
    #1;
    check("restart_sready", {31'd0, sready}, 32'd0);
    beats0 = n_beats;
    tick();
    load_start = 1'b0;
    svalid     = 1'b0;
    #1;
    check("restart_no_beat", n_beats - beats0, 32'd0);
    check("restart_fsm_rst", {31'd0, fsm_rst}, 32'd1);
    send_key(8'h3C);
    svalid = 1'b0;
    check("reload_commit_fsm_rst", {31'd0, fsm_rst}, 32'd1);
    tick();
    check("reload_keyinput",      {24'd0, keyinput}, 32'h3C);
    check("reload_fsm_rst_held",  {31'd0, fsm_rst},  32'd1);
    tick();
    check("reload_fsm_rst_rel",   {31'd0, fsm_rst},  32'd0);

    // Gapped handshake while loading 0x5A.
    do_start();
    beats0 = n_beats;
    send_key_gapped(8'h5A);
    for (int i = 0; i < 4; i++) tick();
`ifdef KEY_LOADER_PARITY_EN
    check("gapped_beats", n_beats - beats0, KEY_W + 1);
`else
    check("gapped_beats", n_beats - beats0, KEY_W);
`endif
    check("gapped_keyinput",  {24'd0, keyinput},  32'h5A);
    check("gapped_key_valid", {31'd0, key_valid}, 32'd1);
    check("gapped_fsm_rst",   {31'd0, fsm_rst},   32'd0);

    // Asynchronous reset mid-load takes effect without a clock edge.
    do_start();
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    svalid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_keyinput",  {24'd0, keyinput},  32'h00);
    check("arst_key_valid", {31'd0, key_valid}, 32'd0);
    check("arst_fsm_rst",   {31'd0, fsm_rst},   32'd1);
    check("arst_busy",      {31'd0, busy},      32'd0);
    check("arst_sready",    {31'd0, sready},    32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post_arst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
